// File: rtl/gpu_decode_loopctl.sv
// Decode/control stage: turns primitive opcodes into registered geometry commands
// and runs a nested hardware-loop stack with a single-cycle redirect to fetch.
module gpu_decode_loopctl #(
    parameter int PC_WIDTH    = 16,
    parameter int CNT_WIDTH   = 16,
    parameter int LOOP_DEPTH  = 4,
    parameter int VEC_WIDTH   = 64,
    parameter int PTYPE_WIDTH = 4,
    localparam int IDX_W      = $clog2(LOOP_DEPTH),
    localparam int LVL_W      = IDX_W + 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   Instr_Valid,
    output logic                   Instr_Ready,
    input  logic [31:0]            Instruction,
    input  logic [PC_WIDTH-1:0]    PC,
    output logic [5:0]             Vec_SR1_Num,
    input  logic [VEC_WIDTH-1:0]   Vec_SR1_Val,
    output logic                   Cmd_Valid,
    input  logic                   Cmd_Ready,
    output logic [1:0]             Cmd_Type,
    output logic [VEC_WIDTH-1:0]   Vertex,
    output logic [PTYPE_WIDTH-1:0] PrimitiveType,
    output logic                   Redirect,
    output logic [PC_WIDTH-1:0]    Redirect_PC,
    output logic [LVL_W-1:0]       Loop_Level,
    output logic                   Loop_Err
);

    typedef enum logic [1:0] {
        CMD_SETVERTEX = 2'd0,
        CMD_STARTPRIM = 2'd1,
        CMD_ENDPRIM   = 2'd2,
        CMD_DRAW      = 2'd3
    } cmd_type_e;

    localparam logic [7:0] OP_SETVERTEX = 8'h42;
    localparam logic [7:0] OP_STARTPRIM = 8'h91;
    localparam logic [7:0] OP_ENDPRIM   = 8'h98;
    localparam logic [7:0] OP_DRAW      = 8'hB8;
    localparam logic [7:0] OP_LOOPCOUNT = 8'hD1;
    localparam logic [7:0] OP_STARTLOOP = 8'hC0;
    localparam logic [7:0] OP_ENDLOOP   = 8'hC8;

    logic                   cmd_valid_q, cmd_valid_d;
    cmd_type_e              cmd_type_q, cmd_type_d;
    logic [VEC_WIDTH-1:0]   vertex_q, vertex_d;
    logic [PTYPE_WIDTH-1:0] ptype_q, ptype_d;
    logic                   redirect_q, redirect_d;
    logic [PC_WIDTH-1:0]    redirect_pc_q, redirect_pc_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   loop_err_q, loop_err_d;
    logic [CNT_WIDTH-1:0]   pend_q, pend_d;
    logic [PC_WIDTH-1:0]    stk_start_q [LOOP_DEPTH];
    logic [PC_WIDTH-1:0]    stk_start_d [LOOP_DEPTH];
    logic [CNT_WIDTH-1:0]   stk_cnt_q   [LOOP_DEPTH];
    logic [CNT_WIDTH-1:0]   stk_cnt_d   [LOOP_DEPTH];

    logic [7:0]             opcode;
    logic                   accept;
    logic                   live;
    logic                   stack_empty;
    logic                   stack_full;
    logic [LVL_W-1:0]       level_m1;
    logic [IDX_W-1:0]       top_idx;
    logic [IDX_W-1:0]       push_idx;
    logic [CNT_WIDTH-1:0]   top_cnt;
    logic [CNT_WIDTH-1:0]   count_field;
    logic                   unused_instr_bits;

    assign opcode            = Instruction[31:24];
    assign count_field       = Instruction[CNT_WIDTH-1:0];
    assign unused_instr_bits = &{1'b0, Instruction[23:22]};
    assign Vec_SR1_Num       = Instruction[21:16];
    assign Instr_Ready       = !cmd_valid_q || Cmd_Ready;
    assign accept            = Instr_Valid && Instr_Ready;
    // The slot accepted while Redirect is high is wrong-path and must not act.
    assign live              = accept && !redirect_q;
    assign stack_empty       = (level_q == '0);
    assign stack_full        = (level_q == LVL_W'(LOOP_DEPTH));
    assign level_m1          = level_q - LVL_W'(1);
    assign top_idx           = level_m1[IDX_W-1:0];
    assign push_idx          = level_q[IDX_W-1:0];
    assign top_cnt           = stk_cnt_q[top_idx];

    // NOTE: every *_d gets a default before the case, so no path can infer a latch.
    always_comb begin
        cmd_valid_d   = cmd_valid_q && !Cmd_Ready;
        cmd_type_d    = cmd_type_q;
        vertex_d      = vertex_q;
        ptype_d       = ptype_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        level_d       = level_q;
        loop_err_d    = loop_err_q;
        pend_d        = pend_q;
        stk_start_d   = stk_start_q;
        stk_cnt_d     = stk_cnt_q;

        if (live) begin
            case (opcode)
                OP_SETVERTEX: begin
                    cmd_valid_d = 1'b1;
                    cmd_type_d  = CMD_SETVERTEX;
                    vertex_d    = Vec_SR1_Val;
                    ptype_d     = '0;
                end
                OP_STARTPRIM: begin
                    cmd_valid_d = 1'b1;
                    cmd_type_d  = CMD_STARTPRIM;
                    vertex_d    = '0;
                    ptype_d     = Instruction[16 +: PTYPE_WIDTH];
                end
                OP_ENDPRIM: begin
                    cmd_valid_d = 1'b1;
                    cmd_type_d  = CMD_ENDPRIM;
                    vertex_d    = '0;
                    ptype_d     = '0;
                end
                OP_DRAW: begin
                    cmd_valid_d = 1'b1;
                    cmd_type_d  = CMD_DRAW;
                    vertex_d    = '0;
                    ptype_d     = '0;
                end
                OP_LOOPCOUNT: begin
                    pend_d = (count_field == '0) ? CNT_WIDTH'(1) : count_field;
                end
                OP_STARTLOOP: begin
                    pend_d = CNT_WIDTH'(1);
                    if (stack_full) begin
                        loop_err_d = 1'b1;
                    end else begin
                        stk_start_d[push_idx] = PC + PC_WIDTH'(1);
                        stk_cnt_d[push_idx]   = pend_q;
                        level_d               = level_q + LVL_W'(1);
                    end
                end
                OP_ENDLOOP: begin
                    if (stack_empty) begin
                        loop_err_d = 1'b1;
                    end else if (top_cnt > CNT_WIDTH'(1)) begin
                        stk_cnt_d[top_idx] = top_cnt - CNT_WIDTH'(1);
                        redirect_d         = 1'b1;
                        redirect_pc_d      = stk_start_q[top_idx];
                    end else begin
                        level_d = level_m1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the loop stack is reset too, so a fresh program never sees stale entries.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cmd_valid_q   <= 1'b0;
            cmd_type_q    <= CMD_SETVERTEX;
            vertex_q      <= '0;
            ptype_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            level_q       <= '0;
            loop_err_q    <= 1'b0;
            pend_q        <= CNT_WIDTH'(1);
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                stk_start_q[i] <= '0;
                stk_cnt_q[i]   <= '0;
            end
        end else begin
            cmd_valid_q   <= cmd_valid_d;
            cmd_type_q    <= cmd_type_d;
            vertex_q      <= vertex_d;
            ptype_q       <= ptype_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            level_q       <= level_d;
            loop_err_q    <= loop_err_d;
            pend_q        <= pend_d;
            stk_start_q   <= stk_start_d;
            stk_cnt_q     <= stk_cnt_d;
        end
    end

    assign Cmd_Valid     = cmd_valid_q;
    assign Cmd_Type      = cmd_type_q;
    assign Vertex        = vertex_q;
    assign PrimitiveType = ptype_q;
    assign Redirect      = redirect_q;
    assign Redirect_PC   = redirect_pc_q;
    assign Loop_Level    = level_q;
    assign Loop_Err      = loop_err_q;

endmodule

// File: tb/tb_gpu_decode_loopctl.sv
// Scoreboard bench for gpu_decode_loopctl: a fetch model walks small programs,
// follows redirects, and queues the commands that must come out.
module tb_gpu_decode_loopctl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        Instr_Valid = 1'b0;
    logic        Instr_Ready;
    logic [31:0] Instruction = 32'h0;
    logic [15:0] PC = 16'h0;
    logic [5:0]  Vec_SR1_Num;
    logic [63:0] Vec_SR1_Val;
    logic        Cmd_Valid;
    logic        Cmd_Ready = 1'b1;
    logic [1:0]  Cmd_Type;
    logic [63:0] Vertex;
    logic [3:0]  PrimitiveType;
    logic        Redirect;
    logic [15:0] Redirect_PC;
    logic [2:0]  Loop_Level;
    logic        Loop_Err;

    gpu_decode_loopctl dut (
        .CLK(CLK), .RESET(RESET),
        .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready),
        .Instruction(Instruction), .PC(PC),
        .Vec_SR1_Num(Vec_SR1_Num), .Vec_SR1_Val(Vec_SR1_Val),
        .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Type(Cmd_Type),
        .Vertex(Vertex), .PrimitiveType(PrimitiveType),
        .Redirect(Redirect), .Redirect_PC(Redirect_PC),
        .Loop_Level(Loop_Level), .Loop_Err(Loop_Err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]  ty;
        logic [63:0] vx;
        logic [3:0]  pt;
    } cmd_t;

    cmd_t        exp_q[$];
    logic [63:0] vrf [64];
    logic [31:0] prog [64];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_redir = 0;
    int          n_draw = 0;
    logic [15:0] last_rpc = 16'h0;
    logic [2:0]  lvl_peak = 3'd0;
    logic        prev_red = 1'b0;

    assign Vec_SR1_Val = vrf[Vec_SR1_Num];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] op(input logic [7:0] o, input logic [23:0] f);
        return {o, f};
    endfunction

    task automatic push_expected(input logic [31:0] ins);
        cmd_t e;
        e.vx = 64'h0;
        e.pt = 4'h0;
        case (ins[31:24])
            8'h42: begin e.ty = 2'd0; e.vx = vrf[ins[21:16]]; exp_q.push_back(e); end
            8'h91: begin e.ty = 2'd1; e.pt = ins[19:16];      exp_q.push_back(e); end
            8'h98: begin e.ty = 2'd2;                         exp_q.push_back(e); end
            8'hB8: begin e.ty = 2'd3;                         exp_q.push_back(e); end
            default: ;
        endcase
    endtask

    // Fetch model: present prog[pc] until accepted; on Redirect jump and drop the shadow slot.
    task automatic run_prog(input string tag, input int start, input int stop);
        int          pc = start;
        int          cyc = 0;
        logic        acc;
        logic        red;
        logic [15:0] rpc;
        while (pc != stop && cyc < 400) begin
            Instruction = prog[pc];
            PC          = 16'(pc);
            Instr_Valid = 1'b1;
            @(negedge CLK);
            acc = Instr_Ready;
            red = Redirect;
            rpc = Redirect_PC;
            @(posedge CLK);
            #1;
            if (red) begin
                n_redir++;
                last_rpc = rpc;
                pc = int'(rpc);
            end else if (acc) begin
                push_expected(prog[pc]);
                pc++;
            end
            cyc++;
        end
        Instr_Valid = 1'b0;
        check({tag, "_end_pc"}, 64'(pc), 64'(stop));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        check({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Instr_Valid = 1'b0;
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        exp_q.delete();
        RESET = 1'b0;
    endtask

    task automatic clear_stats();
        n_redir  = 0;
        n_draw   = 0;
        lvl_peak = 3'd0;
    endtask

    // Output monitor: pops the scoreboard on every transfer and watches Redirect.
    initial begin
        cmd_t e;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                prev_red = 1'b0;
            end else begin
                if (Redirect) check("redirect_single_pulse", 64'(prev_red), 64'(0));
                prev_red = Redirect;
                if (Loop_Level > lvl_peak) lvl_peak = Loop_Level;
                if (Cmd_Valid && Cmd_Ready) begin
                    if (exp_q.size() == 0) begin
                        check("cmd_unexpected", 64'(Cmd_Type), 64'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("cmd_type", 64'(Cmd_Type), 64'(e.ty));
                        check("cmd_vertex", Vertex, e.vx);
                        check("cmd_ptype", 64'(PrimitiveType), 64'(e.pt));
                        if (Cmd_Type == 2'd3) n_draw++;
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] ins;
        for (int i = 0; i < 64; i++) begin
            vrf[i]  = {32'hA5A5_0000, 32'(i)} ^ 64'h1111_2222_0000_0000;
            prog[i] = 32'h0;
        end
        vrf[1] = 64'h0004_0003_0002_0001;

        // Programs
        prog[0]  = op(8'h91, 24'h03_0000);
        prog[1]  = op(8'hB8, 24'h0);
        prog[9]  = op(8'hD1, 24'h00_0003);
        prog[10] = op(8'hC0, 24'h0);
        prog[11] = op(8'hB8, 24'h0);
        prog[12] = op(8'hC8, 24'h0);
        prog[20] = op(8'hD1, 24'h00_0002);
        prog[21] = op(8'hC0, 24'h0);
        prog[22] = op(8'hD1, 24'h00_0003);
        prog[23] = op(8'hC0, 24'h0);
        prog[24] = op(8'hB8, 24'h0);
        prog[25] = op(8'hC8, 24'h0);
        prog[26] = op(8'hB8, 24'h0);
        prog[27] = op(8'hC8, 24'h0);
        prog[28] = op(8'hB8, 24'h0);
        for (int i = 30; i < 35; i++) prog[i] = op(8'hC0, 24'h0);
        for (int i = 35; i < 40; i++) prog[i] = op(8'hC8, 24'h0);
        prog[40] = op(8'hD1, 24'h00_0000);
        prog[41] = op(8'hC0, 24'h0);
        prog[42] = op(8'hB8, 24'h0);
        prog[43] = op(8'hC8, 24'h0);
        prog[50] = op(8'hC0, 24'h0);
        prog[51] = op(8'hC0, 24'h0);
        prog[52] = op(8'h42, 24'h02_0000);

        // Reset state
        do_reset();
        @(negedge CLK);
        check("rst_cmd_valid", 64'(Cmd_Valid), 64'(0));
        check("rst_cmd_type", 64'(Cmd_Type), 64'(0));
        check("rst_vertex", Vertex, 64'h0);
        check("rst_ptype", 64'(PrimitiveType), 64'(0));
        check("rst_redirect", 64'(Redirect), 64'(0));
        check("rst_redirect_pc", 64'(Redirect_PC), 64'(0));
        check("rst_level", 64'(Loop_Level), 64'(0));
        check("rst_err", 64'(Loop_Err), 64'(0));
        check("rst_instr_ready", 64'(Instr_Ready), 64'(1));
        @(posedge CLK);
        #1;

        // SETVERTEX latency and single-cycle valid
        ins = op(8'h42, 24'h01_0000);
        Cmd_Ready = 1'b1;
        Instruction = ins;
        PC = 16'h0;
        Instr_Valid = 1'b1;
        @(negedge CLK);
        check("sv_instr_ready", 64'(Instr_Ready), 64'(1));
        check("sv_sr1_num", 64'(Vec_SR1_Num), 64'(1));
        @(posedge CLK);
        #1;
        Instr_Valid = 1'b0;
        push_expected(ins);
        @(negedge CLK);
        check("sv_valid", 64'(Cmd_Valid), 64'(1));
        check("sv_type", 64'(Cmd_Type), 64'(0));
        check("sv_vertex", Vertex, 64'h0004_0003_0002_0001);
        @(negedge CLK);
        check("sv_valid_clear", 64'(Cmd_Valid), 64'(0));
        @(posedge CLK);
        #1;

        // Back-pressure: STARTPRIM held, DRAW stalled until Cmd_Ready rises
        clear_stats();
        Cmd_Ready = 1'b0;
        fork
            run_prog("bp", 0, 2);
            begin
                repeat (3) @(negedge CLK);
                check("bp_instr_ready_low", 64'(Instr_Ready), 64'(0));
                check("bp_hold_type", 64'(Cmd_Type), 64'(1));
                check("bp_hold_ptype", 64'(PrimitiveType), 64'(3));
                @(posedge CLK);
                #1;
                Cmd_Ready = 1'b1;
            end
        join
        drain("bp");
        check("bp_draws", 64'(n_draw), 64'(1));

        // Single loop, count 3
        clear_stats();
        run_prog("loop3", 9, 14);
        drain("loop3");
        check("loop3_redirects", 64'(n_redir), 64'(2));
        check("loop3_target", 64'(last_rpc), 64'(11));
        check("loop3_draws", 64'(n_draw), 64'(3));
        check("loop3_level", 64'(Loop_Level), 64'(0));
        check("loop3_err", 64'(Loop_Err), 64'(0));

        // Nested 2x3 with DRAWs in the shadow slots
        clear_stats();
        run_prog("nest", 20, 29);
        drain("nest");
        check("nest_redirects", 64'(n_redir), 64'(5));
        check("nest_draws", 64'(n_draw), 64'(9));
        check("nest_peak", 64'(lvl_peak), 64'(2));
        check("nest_level", 64'(Loop_Level), 64'(0));
        check("nest_err", 64'(Loop_Err), 64'(0));

        // Overflow then underflow
        clear_stats();
        run_prog("ovf", 30, 35);
        @(negedge CLK);
        check("ovf_level", 64'(Loop_Level), 64'(4));
        check("ovf_err", 64'(Loop_Err), 64'(1));
        @(posedge CLK);
        #1;
        run_prog("unf", 35, 40);
        @(negedge CLK);
        check("unf_level", 64'(Loop_Level), 64'(0));
        check("unf_err_sticky", 64'(Loop_Err), 64'(1));
        check("unf_redirects", 64'(n_redir), 64'(0));
        do_reset();
        @(negedge CLK);
        check("err_cleared_by_reset", 64'(Loop_Err), 64'(0));
        @(posedge CLK);
        #1;

        // LOOPCOUNT 0 behaves as a single pass
        clear_stats();
        run_prog("cnt0", 40, 45);
        drain("cnt0");
        check("cnt0_draws", 64'(n_draw), 64'(1));
        check("cnt0_redirects", 64'(n_redir), 64'(0));
        check("cnt0_level", 64'(Loop_Level), 64'(0));

        // Reset mid-loop with a stalled command
        Cmd_Ready = 1'b0;
        run_prog("midrst", 50, 53);
        @(negedge CLK);
        check("midrst_level_before", 64'(Loop_Level), 64'(2));
        check("midrst_valid_before", 64'(Cmd_Valid), 64'(1));
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        check("midrst_level", 64'(Loop_Level), 64'(0));
        check("midrst_valid", 64'(Cmd_Valid), 64'(0));
        check("midrst_redirect", 64'(Redirect), 64'(0));
        @(posedge CLK);
        #1;
        Cmd_Ready = 1'b1;

        // Pending count defaults to 1 after reset
        clear_stats();
        run_prog("pend_dflt", 41, 45);
        drain("pend_dflt");
        check("pend_dflt_draws", 64'(n_draw), 64'(1));
        check("pend_dflt_redirects", 64'(n_redir), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpu_decode_loopctl.md
Name: gpu_decode_loopctl

Overview:
- Next-generation decode/control stage for the GPU pipeline.
- Decodes primitive-control and loop opcodes from fetch and emits one registered command per instruction to the geometry stage, using a valid/ready handshake.
- Supports hardware loops nested up to LOOP_DEPTH, each with its own counter, and reports loop-stack errors.
- Arithmetic and move opcodes are consumed with no effect here; the register-file stage handles them.

Parameters:
PC_WIDTH, 16, program counter width
CNT_WIDTH, 16, loop iteration counter width
LOOP_DEPTH, 4, maximum nested loop levels (power of 2, >=2)
VEC_WIDTH, 64, vertex vector width
PTYPE_WIDTH, 4, primitive type field width

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  reset; one clock; reset is synchronous and active-high
Instr_Valid  in  1  fetch presents an instruction
Instr_Ready  out  1  decode accepts this cycle; combinational, = !Cmd_Valid | Cmd_Ready
Instruction  in  32  opcode in [31:24]
PC  in  PC_WIDTH  address of Instruction
Vec_SR1_Num  out  6  = Instruction[21:16]; vector regfile read address
Vec_SR1_Val  in  VEC_WIDTH  combinational read data
Cmd_Valid  out  1  command register full
Cmd_Ready  in  1  consumer accepts
Cmd_Type  out  2  0 SETVERTEX, 1 STARTPRIM, 2 ENDPRIM, 3 DRAW
Vertex  out  VEC_WIDTH  vertex for SETVERTEX, else 0
PrimitiveType  out  PTYPE_WIDTH  Instruction[16+PTYPE_WIDTH-1:16] for STARTPRIM, else 0
Redirect  out  1  one-cycle pulse: fetch must jump
Redirect_PC  out  PC_WIDTH  jump target, valid while Redirect=1
Loop_Level  out  log2(LOOP_DEPTH)+1  current stack occupancy
Loop_Err  out  1  sticky overflow/underflow flag

Behaviour:
- Accept = Instr_Valid & Instr_Ready. Nothing changes state without accept, except the command pop and Redirect clear.
- Opcodes:
  - 8'h42 SETVERTEX
  - 8'h91 STARTPRIM
  - 8'h98 ENDPRIM
  - 8'hB8 DRAW
  - 8'hD1 LOOPCOUNT, count in Instruction[CNT_WIDTH-1:0]
  - 8'hC0 STARTLOOP
  - 8'hC8 ENDLOOP
  - All others: accepted, no effect.
- Command register:
  - An accepted command opcode loads Cmd_Type/Vertex/PrimitiveType and sets Cmd_Valid on the next edge.
  - Cmd_Valid & Cmd_Ready with no new load: Cmd_Valid clears.
  - Pop and new load in the same cycle: stays valid, holds the new values.
  - Outputs are stable while Cmd_Valid & !Cmd_Ready.
  - Latency: command appears 1 cycle after accept.
- Pending count register Pend (reset 1):
  - LOOPCOUNT n sets Pend = (n==0 ? 1 : n).
  - Any STARTLOOP resets Pend to 1 after use.
- STARTLOOP, stack not full: push {start = PC+1 (mod 2^PC_WIDTH), cnt = Pend}; Loop_Level+1.
- STARTLOOP, stack full: no push, Loop_Err <= 1; the body runs once.
- ENDLOOP, top cnt > 1:
  - top cnt decrements.
  - Next cycle Redirect=1, Redirect_PC = top start.
- ENDLOOP, top cnt == 1: pop, Loop_Level-1, no redirect.
- ENDLOOP, stack empty: Loop_Err <= 1, no redirect, no level change.
- Shadow slot: any instruction accepted during the Redirect=1 cycle is discarded. It is wrong-path, so there are no command, stack or Pend effects. Instr_Ready is still asserted.
- Redirect is a registered single-cycle pulse; it is never high two consecutive cycles.
- Loop_Err is cleared only by RESET.
- Reset values:
  - Cmd_Valid=0, Cmd_Type=0, Vertex=0, PrimitiveType=0
  - Redirect=0, Redirect_PC=0
  - Loop_Level=0, Loop_Err=0, Pend=1
  - stack entries = 0
- RESET mid-loop or mid-stall: all of the above take effect on that edge; a pending command is dropped.
- Counter arithmetic: unsigned CNT_WIDTH, no wrap possible (decrement only when >1).

Test Plan:
- Reset, then SETVERTEX with Vec_SR1_Val=64'h0004_0003_0002_0001, Cmd_Ready=1 -> next cycle Cmd_Valid=1, Cmd_Type=0, Vertex=64'h0004_0003_0002_0001; following cycle Cmd_Valid=0.
- Cmd_Ready=0, then STARTPRIM type 4'h3 followed by DRAW -> STARTPRIM held with Instr_Ready=0. Raise Cmd_Ready -> DRAW accepted; next cycle Cmd_Type=3. No command is lost or duplicated.
- LOOPCOUNT 3, STARTLOOP at PC=10, body DRAW at PC=11, ENDLOOP at PC=12 -> Redirect to 11 exactly twice; 3 DRAW commands total; Loop_Level returns to 0; Loop_Err=0.
- Nesting: outer count 2, inner count 3, each with a DRAW body -> 6 inner DRAWs; Loop_Level peaks at 2; shadow-slot instructions produce no commands.
- LOOP_DEPTH=4 with 5 nested STARTLOOPs -> Loop_Err=1, Loop_Level=4. Then ENDLOOP with the stack emptied -> Loop_Err stays 1, no Redirect.
- LOOPCOUNT 0 then a loop -> body executes once, no Redirect. Assert RESET mid-loop at Loop_Level=2 -> Loop_Level=0, Cmd_Valid=0, Redirect=0 on the next edge.
